// File: rtl/bitstream_scan_ctrl_if.sv
// bitstream_scan_ctrl_if: per-channel result valid/ready channel of the scan sequencer.
interface bitstream_scan_ctrl_if #(
  parameter int P_SEL_WIDTH = 4,
  parameter int P_ACC_WIDTH = 24
);
  logic                   res_valid;
  logic                   res_ready;
  logic [P_SEL_WIDTH-1:0] res_ch;
  logic [P_ACC_WIDTH-1:0] res_sum;
  logic                   res_sat;
  modport master (output res_valid, res_ch, res_sum, res_sat, input res_ready);
  modport slave  (input res_valid, res_ch, res_sum, res_sat, output res_ready);
endinterface

// File: rtl/bitstream_scan_ctrl.sv
// bitstream_scan_ctrl: scans a channel range through one shared bitstream counter, summing window counts per channel.
module bitstream_scan_ctrl #(
  parameter int P_N_WIDTH      = 16,
  parameter int P_SEL_WIDTH    = 4,
  parameter int P_SETTLE_WIDTH = 8,
  parameter int P_ACC_WIDTH    = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [P_SEL_WIDTH-1:0]    ch_first,
  input  logic [P_SEL_WIDTH-1:0]    ch_last,
  input  logic [P_N_WIDTH-1:0]      period_cfg,
  input  logic [7:0]                n_windows,
  input  logic [P_SETTLE_WIDTH-1:0] settle,
  output logic                      cnt_rst,
  output logic                      cnt_inh,
  output logic [P_N_WIDTH-1:0]      cnt_period,
  output logic [P_SEL_WIDTH-1:0]    sel,
  input  logic                      cnt_update,
  input  logic [P_N_WIDTH-1:0]      cnt_n,
  output logic                      busy,
  output logic                      done,
  bitstream_scan_ctrl_if.master     res
);
  typedef enum logic [2:0] {IDLE, SETTLE, ARM, COUNT, EMIT} state_t;
  state_t                    state_q, state_d;
  logic [P_SEL_WIDTH-1:0]    sel_q, sel_d, last_q, last_d;
  logic [P_N_WIDTH-1:0]      period_q, period_d;
  logic [7:0]                nwin_q, nwin_d, wcnt_q, wcnt_d, nw;
  logic [P_SETTLE_WIDTH-1:0] settle_q, settle_d, scnt_q, scnt_d;
  logic [P_ACC_WIDTH-1:0]    sum_q, sum_d;
  logic [P_ACC_WIDTH:0]      add;
  logic sat_q, sat_d, busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic cnt_rst_q, cnt_rst_d, cnt_inh_q, cnt_inh_d;
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    period_d = period_q;
    nwin_d   = nwin_q;
    wcnt_d   = wcnt_q;
    settle_d = settle_q;
    scnt_d   = scnt_q;
    sum_d    = sum_q;
    sat_d    = sat_q;
    done_d   = 1'b0;
    nw       = (n_windows == 8'd0) ? 8'd1 : n_windows;
    add      = {1'b0, sum_q} + (P_ACC_WIDTH+1)'(cnt_n);
    case (state_q)
      IDLE: if (start && !abort) begin
        state_d  = SETTLE;
        sel_d    = ch_first;
        last_d   = ch_last;
        period_d = (period_cfg < P_N_WIDTH'(2)) ? P_N_WIDTH'(2) : period_cfg;
        nwin_d   = nw;
        wcnt_d   = nw;
        settle_d = settle;
        scnt_d   = settle;
        sum_d    = '0;
        sat_d    = 1'b0;
      end
      SETTLE: if (scnt_q == '0) state_d = ARM; else scnt_d = scnt_q - 1'b1;
      ARM: if (cnt_update) state_d = COUNT;
      COUNT: if (cnt_update) begin
        sum_d  = add[P_ACC_WIDTH] ? '1 : add[P_ACC_WIDTH-1:0];
        sat_d  = sat_q | add[P_ACC_WIDTH] | (&cnt_n);
        wcnt_d = wcnt_q - 1'b1;
        if (wcnt_q == 8'd1) state_d = EMIT;
      end
      EMIT: if (res.res_ready) begin
        if (sel_q == last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = SETTLE;
          sel_d   = sel_q + 1'b1;
          scnt_d  = settle_q;
          wcnt_d  = nwin_q;
          sum_d   = '0;
          sat_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // abort overrides every event above, including a same-cycle handshake
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
    busy_d    = state_d != IDLE;
    valid_d   = state_d == EMIT;
    cnt_rst_d = state_d == IDLE || state_d == SETTLE;
    cnt_inh_d = !(state_d == ARM || state_d == COUNT);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      last_q    <= '0;
      period_q  <= '0;
      nwin_q    <= '0;
      wcnt_q    <= '0;
      settle_q  <= '0;
      scnt_q    <= '0;
      sum_q     <= '0;
      sat_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      cnt_rst_q <= 1'b1;
      cnt_inh_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      period_q  <= period_d;
      nwin_q    <= nwin_d;
      wcnt_q    <= wcnt_d;
      settle_q  <= settle_d;
      scnt_q    <= scnt_d;
      sum_q     <= sum_d;
      sat_q     <= sat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      cnt_rst_q <= cnt_rst_d;
      cnt_inh_q <= cnt_inh_d;
    end
  end
  assign cnt_rst       = cnt_rst_q;
  assign cnt_inh       = cnt_inh_q;
  assign cnt_period    = period_q;
  assign sel           = sel_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign res.res_valid = valid_q;
  assign res.res_ch    = sel_q;
  assign res.res_sum   = sum_q;
  assign res.res_sat   = sat_q;
endmodule
